// File: rtl/conv_result_fifo.sv
// Result buffer behind the convolution datapath: captures one word per WRITE command
// and, on a READ command edge, drains all stored words to a valid/ready consumer.
module conv_result_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            fifo_command,
    input  logic [DATA_WIDTH-1:0] result_data,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  drain_busy,
    output logic                  drain_done
);

    localparam int DEPTH = 32'd1 << ADDR_WIDTH;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_e                state_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  full_r;
    logic                  empty_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;
    logic                  overflow_r;
    logic                  drain_busy_r;
    logic                  drain_done_r;
    logic [1:0]            prev_cmd_r;

    logic                  wr_req_s;
    logic                  rd_cmd_s;
    logic                  clr_s;
    logic                  read_edge_s;
    logic                  slot_free_s;
    logic                  wr_en_s;
    logic                  pop_s;
    logic                  drain_end_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;

    // Command decode
    always_comb begin
        wr_req_s = 1'b0;
        rd_cmd_s = 1'b0;
        clr_s    = 1'b0;
        case (fifo_command)
            CMD_WRITE: wr_req_s = 1'b1;
            CMD_READ:  rd_cmd_s = 1'b1;
            CMD_CLEAR: clr_s    = 1'b1;
            default:   wr_req_s = 1'b0;
        endcase
    end

    // Write/pop qualification and next occupancy; full is judged on the current count only
    always_comb begin
        read_edge_s = rd_cmd_s && (prev_cmd_r != CMD_READ);
        slot_free_s = !rd_valid_r || rd_ready;
        wr_en_s     = wr_req_s && !full_r && !reset;
        pop_s       = (state_r == ST_DRAIN) && slot_free_s && (count_r != CNT_ZERO);
        drain_end_s = (state_r == ST_DRAIN) && slot_free_s && (count_r == CNT_ZERO);
        if (wr_en_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !wr_en_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array, deliberately left uninitialised by reset and CLEAR
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= result_data;
        end
    end

    // Control state, pointers, status flags and the output register
    always_ff @(posedge clk) begin
        if (reset || clr_s) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            rd_data_r    <= DATA_ZERO;
            rd_valid_r   <= 1'b0;
            overflow_r   <= 1'b0;
            drain_busy_r <= 1'b0;
            drain_done_r <= 1'b0;
            prev_cmd_r   <= CMD_IDLE;
        end else begin
            prev_cmd_r   <= fifo_command;
            count_r      <= count_nxt_s;
            full_r       <= (count_nxt_s == CNT_FULL);
            empty_r      <= (count_nxt_s == CNT_ZERO);
            drain_done_r <= drain_end_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (wr_req_s && full_r) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (read_edge_s) begin
                        state_r      <= ST_DRAIN;
                        drain_busy_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_end_s) begin
                        state_r      <= ST_IDLE;
                        drain_busy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    drain_busy_r <= 1'b0;
                end
            endcase
            if (pop_s) begin
                rd_data_r  <= mem_r[rd_ptr_r];
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                rd_valid_r <= 1'b1;
            end else if (rd_valid_r && rd_ready) begin
                rd_valid_r <= 1'b0;
            end
        end
    end

    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;
    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign drain_busy = drain_busy_r;
    assign drain_done = drain_done_r;

endmodule

// File: tb/tb_conv_result_fifo.sv
// Self-checking bench for conv_result_fifo: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_conv_result_fifo;

    localparam int DW = 18;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    fifo_command;
    logic [DW-1:0] result_data;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          drain_busy;
    logic          drain_done;

    conv_result_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_command (fifo_command),
        .result_data  (result_data),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drain_busy   (drain_busy),
        .drain_done   (drain_done)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_tests = 0;
    int cyc_fails = 0;
    bit check_en = 1'b0;

    // Reference model state: storage as a queue, plus output word and drain flag
    logic [DW-1:0] store_q[$];
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ovf;
    logic          m_drain;
    logic          m_done;
    logic [1:0]    m_prev;

    // Receiver-side records gathered by the compare process
    logic [DW-1:0] rx_q[$];
    int            done_pulses = 0;
    int            valid_cycles = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] hold_data;

    // Reference model update at every active edge
    always @(posedge clk) begin : model
        bit slot;
        bit take;
        bit fin;
        if (reset || fifo_command == 2'b11) begin
            store_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_drain = 1'b0;
            m_done  = 1'b0;
            m_prev  = 2'b00;
        end else begin
            slot = !m_valid || rd_ready;
            take = m_drain && slot && (store_q.size() > 0);
            fin  = m_drain && slot && (store_q.size() == 0);
            if (take) begin
                m_data  = store_q.pop_front();
                m_valid = 1'b1;
            end else if (m_valid && rd_ready) begin
                m_valid = 1'b0;
            end
            if (fifo_command == 2'b10) begin
                if (store_q.size() + (take ? 1 : 0) >= 512) m_ovf = 1'b1;
                else store_q.push_back(result_data);
            end
            m_done = fin;
            if (!m_drain && fifo_command == 2'b01 && m_prev != 2'b01) m_drain = 1'b1;
            else if (fin) m_drain = 1'b0;
            m_prev = fifo_command;
        end
    end

    function automatic void ccheck(input string name, input logic [31:0] act, input logic [31:0] exp);
        cyc_tests++;
        if (act !== exp) begin
            cyc_fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Per-cycle comparison of every output against the model, away from the active edge
    always @(negedge clk) begin : cmp
        if (check_en) begin
            ccheck("rd_valid", 32'(rd_valid), 32'(m_valid));
            ccheck("rd_data", 32'(rd_data), 32'(m_data));
            ccheck("fifo_count", 32'(fifo_count), store_q.size());
            ccheck("fifo_full", 32'(fifo_full), 32'(store_q.size() == 512));
            ccheck("fifo_empty", 32'(fifo_empty), 32'(store_q.size() == 0));
            ccheck("overflow", 32'(overflow), 32'(m_ovf));
            ccheck("drain_busy", 32'(drain_busy), 32'(m_drain));
            ccheck("drain_done", 32'(drain_done), 32'(m_done));
            if (stalled) begin
                ccheck("stall_hold_data", 32'(rd_data), 32'(hold_data));
                ccheck("stall_hold_valid", 32'(rd_valid), 32'd1);
            end
            if (rd_valid && rd_ready) rx_q.push_back(rd_data);
            if (drain_done) done_pulses++;
            if (rd_valid) valid_cycles++;
            stalled   = rd_valid && !rd_ready && !reset && (fifo_command != 2'b11);
            hold_data = rd_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [DW-1:0] d, input logic r);
        fifo_command = c;
        result_data  = d;
        rd_ready     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'b00, 18'h0, 1'b0);
        reset = 1'b0;
        check_en = 1'b1;
    endtask

    task automatic drain_until_done(input string name, input logic [1:0] c, input int max_cycles);
        int n = 0;
        while (!drain_done && n < max_cycles) begin
            step(c, 18'h0, 1'b1);
            n++;
        end
        check(name, 32'(drain_done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int dbase;
        int vbase;
        int n;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        fifo_command = 2'b00;
        result_data = 18'h0;
        rd_ready = 1'b0;

        // Test 1: reset state, three-word drain with latency pins
        do_reset();
        check("reset_empty", 32'(fifo_empty), 32'd1);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_data", 32'(rd_data), 32'd0);
        base = rx_q.size();
        dbase = done_pulses;
        step(2'b10, 18'h00011, 1'b1);
        step(2'b10, 18'h00022, 1'b1);
        step(2'b10, 18'h00033, 1'b1);
        check("t1_count3", 32'(fifo_count), 32'd3);
        step(2'b01, 18'h0, 1'b1);
        check("t1_busy_t1", 32'(drain_busy), 32'd1);
        check("t1_valid_t1", 32'(rd_valid), 32'd0);
        step(2'b01, 18'h0, 1'b1);
        check("t1_valid_t2", 32'(rd_valid), 32'd1);
        check("t1_data_t2", 32'(rd_data), 32'h11);
        step(2'b01, 18'h0, 1'b1);
        check("t1_data_t3", 32'(rd_data), 32'h22);
        step(2'b01, 18'h0, 1'b1);
        check("t1_data_t4", 32'(rd_data), 32'h33);
        step(2'b01, 18'h0, 1'b1);
        check("t1_done_t5", 32'(drain_done), 32'd1);
        check("t1_valid_t5", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(2'b01, 18'h0, 1'b1);
        check("t1_done_once", done_pulses - dbase, 32'd1);
        check("t1_rx_size", rx_q.size() - base, 32'd3);
        check("t1_rx0", 32'(rx_q[base]), 32'h11);
        check("t1_rx1", 32'(rx_q[base+1]), 32'h22);
        check("t1_rx2", 32'(rx_q[base+2]), 32'h33);
        check("t1_empty", 32'(fifo_empty), 32'd1);

        // Test 2: backpressure with ready pattern 1,0,0,1
        do_reset();
        base = rx_q.size();
        for (int i = 0; i < 4; i++) step(2'b10, 18'(32'h101 + i), 1'b0);
        step(2'b01, 18'h0, 1'b1);
        for (int k = 0; k < 24; k++) step(2'b01, 18'h0, pat[k % 4]);
        check("t2_rx_size", rx_q.size() - base, 32'd4);
        for (int i = 0; i < 4; i++) check("t2_rx_order", 32'(rx_q[base+i]), 32'h101 + i);

        // Test 4: concurrent write and drain across the address wrap
        do_reset();
        for (int i = 0; i < 505; i++) step(2'b10, 18'(i), 1'b0);
        step(2'b01, 18'h0, 1'b1);
        drain_until_done("t4_pre_drain_timeout", 2'b00, 600);
        step(2'b00, 18'h0, 1'b0);
        check("t4_pre_count", 32'(fifo_count), 32'd0);
        base = rx_q.size();
        for (int i = 0; i < 10; i++) step(2'b10, 18'(32'h200 + i), 1'b0);
        step(2'b01, 18'h0, 1'b1);
        check("t4_count_start", 32'(fifo_count), 32'd10);
        for (int j = 0; j < 12; j++) begin
            step(2'b10, 18'(32'h300 + j), 1'b1);
            check("t4_count_steady", 32'(fifo_count), 32'd10);
        end
        drain_until_done("t4_drain_timeout", 2'b00, 100);
        step(2'b00, 18'h0, 1'b1);
        check("t4_rx_size", rx_q.size() - base, 32'd22);
        for (int i = 0; i < 10; i++) check("t4_rx_first", 32'(rx_q[base+i]), 32'h200 + i);
        for (int j = 0; j < 12; j++) check("t4_rx_second", 32'(rx_q[base+10+j]), 32'h300 + j);

        // Test 3: fill, overflow, sticky overflow until CLEAR
        do_reset();
        for (int i = 0; i < 512; i++) step(2'b10, 18'(i), 1'b0);
        check("t3_full", 32'(fifo_full), 32'd1);
        check("t3_count512", 32'(fifo_count), 32'd512);
        check("t3_no_ovf_yet", 32'(overflow), 32'd0);
        step(2'b10, 18'h3FFFF, 1'b0);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_count_kept", 32'(fifo_count), 32'd512);
        base = rx_q.size();
        step(2'b01, 18'h0, 1'b1);
        drain_until_done("t3_drain_timeout", 2'b00, 600);
        step(2'b00, 18'h0, 1'b1);
        check("t3_rx_size", rx_q.size() - base, 32'd512);
        check("t3_rx_first", 32'(rx_q[base]), 32'd0);
        check("t3_rx_last", 32'(rx_q[base+511]), 32'd511);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        step(2'b11, 18'h0, 1'b0);
        check("t3_ovf_cleared", 32'(overflow), 32'd0);

        // Test 5: READ held on empty storage
        do_reset();
        dbase = done_pulses;
        vbase = valid_cycles;
        for (int i = 0; i < 50; i++) step(2'b01, 18'h0, 1'b1);
        step(2'b00, 18'h0, 1'b1);
        check("t5_done_once", done_pulses - dbase, 32'd1);
        check("t5_never_valid", valid_cycles - vbase, 32'd0);

        // Test 6: reset, then CLEAR, after two of five words delivered
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            base = rx_q.size();
            for (int i = 0; i < 5; i++) step(2'b10, 18'(32'h41 + i), 1'b0);
            step(2'b01, 18'h0, 1'b1);
            n = 0;
            while (rx_q.size() - base < 2 && n < 20) begin
                step(2'b01, 18'h0, 1'b1);
                n++;
            end
            check("t6_two_delivered", rx_q.size() - base, 32'd2);
            dbase = done_pulses;
            if (mode == 0) begin
                reset = 1'b1;
                step(2'b01, 18'h0, 1'b1);
                reset = 1'b0;
            end else begin
                step(2'b11, 18'h0, 1'b1);
            end
            check("t6_valid", 32'(rd_valid), 32'd0);
            check("t6_count", 32'(fifo_count), 32'd0);
            check("t6_busy", 32'(drain_busy), 32'd0);
            check("t6_done", 32'(drain_done), 32'd0);
            for (int i = 0; i < 3; i++) step(2'b00, 18'h0, 1'b1);
            check("t6_no_done_pulse", done_pulses - dbase, 32'd0);
        end

        step(2'b00, 18'h0, 1'b0);
        tests = tests + cyc_tests;
        fails = fails + cyc_fails;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
